bin2bcd_4digit: RTL

BIN2BCD_4DIGIT -- requirements
Module: bin2bcd_4digit

---
 rtl/bcd_pkg.sv | 29 ++
 rtl/bcd_add3.sv | 14 +
 rtl/bin2bcd_4digit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the binary-to-BCD converter.
// FSM state encoding, BCD digit type and decimal limits.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam int BCD_MAX_DEC = 9999;
    localparam int BCD_NIBBLES = 5;

    // Decimal digit 'pos' (0 = ones) of a constant value.
    function automatic bcd_digit_t dec_digit(input int value, input int pos);
        int v;
        v = value;
        case (pos)
            1:       v = v / 10;
            2:       v = v / 100;
            3:       v = v / 1000;
            default: v = value;
        endcase
        return bcd_digit_t'(v % 10);
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble nibble correction.
// A nibble of 5 or more gets 3 added so the next shift carries cleanly.
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    // Correct the nibble ahead of the shift.
    always_comb begin
        q = d;
        if (d >= 4'd5) q = d + 4'd3;
    end

endmodule

// File: rtl/bin2bcd_4digit.sv
// bin2bcd_4digit: sequential shift-add-3 binary to 4-digit BCD converter.
// Define BIN2BCD_SATURATE_EN to clamp results above 9999 and drive ovf.
module bin2bcd_4digit
    import bcd_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BIN_W-1:0] bin,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [3:0]       dig0,
    output logic [3:0]       dig1,
    output logic [3:0]       dig2,
    output logic [3:0]       dig3,
    output logic             ovf
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int SCR_W = 4 * BCD_NIBBLES;

    state_t           state;
    state_t           state_n;
    logic [BIN_W-1:0] sreg;
    logic [SCR_W-1:0] scratch;
    logic [SCR_W-1:0] corr;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             step;
    logic             finish;
    logic             unused_msb;

    bcd_digit_t r0, r1, r2, r3;
    bcd_digit_t d0_q, d1_q, d2_q, d3_q;
    logic       done_q;

    // Per-nibble add-3 correction of the scratch register.
    for (genvar i = 0; i < BCD_NIBBLES; i++) begin : g_add3
        bcd_add3 u_add3 (
            .d (scratch[4*i +: 4]),
            .q (corr[4*i +: 4])
        );
    end

    // Top corrected bit is shifted out; it can never be set for BIN_W <= 14.
    assign unused_msb = corr[SCR_W-1];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state and datapath control.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt == CNT_W'(1)) state_n = DONE;
            end
            DONE: begin
                finish  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Shift register, BCD scratch and bit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg    <= '0;
            scratch <= '0;
            cnt     <= '0;
        end else if (load) begin
            sreg    <= bin;
            scratch <= '0;
            cnt     <= CNT_W'(BIN_W);
        end else if (step) begin
            {scratch, sreg} <= {corr[SCR_W-2:0], sreg, 1'b0};
            cnt             <= cnt - 1'b1;
        end
    end

`ifdef BIN2BCD_SATURATE_EN
    logic r_ovf;
    logic ovf_q;

    // Clamp to 9999 when the ten-thousands nibble is non-zero.
    always_comb begin
        r_ovf = |scratch[SCR_W-1:16];
        r0    = scratch[3:0];
        r1    = scratch[7:4];
        r2    = scratch[11:8];
        r3    = scratch[15:12];
        if (r_ovf) begin
            r0 = dec_digit(BCD_MAX_DEC, 0);
            r1 = dec_digit(BCD_MAX_DEC, 1);
            r2 = dec_digit(BCD_MAX_DEC, 2);
            r3 = dec_digit(BCD_MAX_DEC, 3);
        end
    end

    // Overflow flag, updated with the digits.
    always_ff @(posedge clk) begin
        if (reset)       ovf_q <= 1'b0;
        else if (finish) ovf_q <= r_ovf;
    end

    assign ovf = ovf_q;
`else
    // Ten-thousands nibble dropped: result is the value mod 10000.
    always_comb begin
        r0 = scratch[3:0];
        r1 = scratch[7:4];
        r2 = scratch[11:8];
        r3 = scratch[15:12];
    end

    assign ovf = 1'b0;
`endif

    // Output digits and done pulse, refreshed only on leaving DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            d0_q   <= '0;
            d1_q   <= '0;
            d2_q   <= '0;
            d3_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= finish;
            if (finish) begin
                d0_q <= r0;
                d1_q <= r1;
                d2_q <= r2;
                d3_q <= r3;
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = done_q;
    assign dig0 = d0_q;
    assign dig1 = d1_q;
    assign dig2 = d2_q;
    assign dig3 = d3_q;

endmodule
